control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/decode/execute sequencer driving a small
// register-file + data-memory datapath. Datapath outputs depend only on state and IR.
module control_unit #(
    parameter int PC_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         instr_data,
    output logic [PC_WIDTH-1:0] pc_addr,
    output logic [15:0]         ir_out,
    output logic [3:0]          state_out,
    output logic [7:0]          d_addr,
    output logic                d_wr,
    output logic                rf_sel,
    output logic                rf_w_en,
    output logic [3:0]          write_addr,
    output logic [3:0]          rd_addr_a,
    output logic [3:0]          rd_addr_b,
    output logic [2:0]          alu_sel
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic [3:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                pc_d    = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr_data;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Decode from the latched IR so the memory bus is free during DECODE.
                case (ir_q[15:12])
                    4'd1:    state_d = S_LOAD_A;
                    4'd2:    state_d = S_STORE;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Reset clears state and IR asynchronously, so every derived output is zero at once.
    always_comb begin
        d_addr  = 8'd0;
        d_wr    = 1'b0;
        rf_sel  = 1'b0;
        rf_w_en = 1'b0;
        alu_sel = 3'd0;
        case (state_q)
            S_LOAD_A: begin
                d_addr = ir_q[11:4];
                rf_sel = 1'b1;
            end
            S_LOAD_B: begin
                d_addr  = ir_q[11:4];
                rf_sel  = 1'b1;
                rf_w_en = 1'b1;
            end
            S_STORE: begin
                d_addr = ir_q[7:0];
                d_wr   = 1'b1;
            end
            S_ADD: begin
                alu_sel = 3'd1;
                rf_w_en = 1'b1;
            end
            S_SUB: begin
                alu_sel = 3'd2;
                rf_w_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_addr    = pc_q;
    assign ir_out     = ir_q;
    assign state_out  = state_q;
    assign write_addr = ir_q[3:0];
    assign rd_addr_a  = ir_q[11:8];
    assign rd_addr_b  = ir_q[7:4];

endmodule
